sp_ram_be_clr: RTL and testbench

Parametrised single-port synchronous RAM, successor to the plain we/addr/din/dout RAM.
- Adds per-byte write enables, a req/ready handshake and a selectable read latency of 1 or 2.
- Adds a selectable write-return mode and an automatic zero-fill of the whole array after reset.
- Sits between a simple master (register file or DMA engine) and local storage; one access per cycle.

---
 rtl/sp_ram_pkg.sv | 27 ++
 rtl/sp_ram_core.sv | 63 ++++++
 rtl/sp_ram_be_clr.sv | 141 ++++++++++++++
 tb/tb_sp_ram_be_clr.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/sp_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sp_ram_pkg
//  Description : Shared types and helpers for the byte-enabled single-port
//                RAM with post-reset zero-fill.
//  Revision    : 1.0  initial release
// ============================================================================
package sp_ram_pkg;

    // Top-level control state: zero-filling the array, or serving accesses
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Write-response modes
    localparam int WR_RET_NONE = 0;
    localparam int WR_RET_NEW  = 1;
    localparam int WR_RET_OLD  = 2;

    // Number of byte lanes in one word
    function automatic int calc_nb(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sp_ram_core.sv
`default_nettype none
// ============================================================================
//  Module      : sp_ram_core
//  Description : Storage array with per-lane write merge and a registered,
//                enable-gated read port (read-before-write). The read port
//                can load either the stored word or the merged write word.
//  Revision    : 1.0  initial release
// ============================================================================
module sp_ram_core
    import sp_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          en,
    input  logic                                          we,
    input  logic [ADDR_WIDTH-1:0]                         addr,
    input  logic [calc_nb(DATA_WIDTH, BYTE_WIDTH)-1:0]    be,
    input  logic [DATA_WIDTH-1:0]                         wdata,
    input  logic                                          rd_en,
    input  logic                                          ret_new,
    output logic [DATA_WIDTH-1:0]                         q
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int NB    = calc_nb(DATA_WIDTH, BYTE_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] w_old;
    logic [DATA_WIDTH-1:0] w_new;

    assign w_old = r_mem[addr];

    // Merge: enabled lanes take write data, others keep the stored bytes
    generate
        for (genvar i = 0; i < NB; i++) begin : g_lane
            assign w_new[i*BYTE_WIDTH +: BYTE_WIDTH] =
                be[i] ? wdata[i*BYTE_WIDTH +: BYTE_WIDTH]
                      : w_old[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    endgenerate

    // Array write: the full merged word is stored, so disabled lanes are unchanged
    always_ff @(posedge clk) begin
        if (en && we) begin
            r_mem[addr] <= w_new;
        end
    end

    // Read register: loads only when a response is due, otherwise holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (rd_en) begin
            q <= ret_new ? w_new : w_old;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sp_ram_be_clr.sv
`default_nettype none
// ============================================================================
//  Module      : sp_ram_be_clr
//  Description : Single-port synchronous RAM with byte enables, req/ready
//                handshake, read latency 1 or 2, selectable write-return
//                mode and automatic zero-fill of the array after reset.
//  Revision    : 1.0  initial release
// ============================================================================
module sp_ram_be_clr
    import sp_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int WR_RETURN  = 0
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          req,
    input  logic                                          we,
    input  logic [ADDR_WIDTH-1:0]                         addr,
    input  logic [calc_nb(DATA_WIDTH, BYTE_WIDTH)-1:0]    be,
    input  logic [DATA_WIDTH-1:0]                         din,
    output logic                                          ready,
    output logic [DATA_WIDTH-1:0]                         dout,
    output logic                                          dout_valid
);

    localparam int NB = calc_nb(DATA_WIDTH, BYTE_WIDTH);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_clr_addr;
    logic                    w_clearing;
    logic                    w_acc;
    logic                    w_resp;
    logic                    w_ret_new;
    logic                    w_core_en;
    logic                    w_core_we;
    logic [ADDR_WIDTH-1:0]   w_core_addr;
    logic [NB-1:0]           w_core_be;
    logic [DATA_WIDTH-1:0]   w_core_wdata;
    logic [DATA_WIDTH-1:0]   w_q;
    logic                    r_v1;

    assign w_clearing = (r_state == CLEAR);
    assign ready      = (r_state == RUN);
    assign w_acc      = req && ready;

    // A response is produced for every read, and for writes unless returns are off
    assign w_resp    = w_acc && (!we || (WR_RETURN != WR_RET_NONE));
    assign w_ret_new = we && (WR_RETURN == WR_RET_NEW);

    // During zero-fill the counter owns the array port
    assign w_core_en    = w_clearing || w_acc;
    assign w_core_we    = w_clearing ? 1'b1 : we;
    assign w_core_addr  = w_clearing ? r_clr_addr : addr;
    assign w_core_be    = w_clearing ? {NB{1'b1}} : be;
    assign w_core_wdata = w_clearing ? '0 : din;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Leave CLEAR on the edge that zeroes the last address
    always_comb begin
        w_state_nxt = r_state;
        if ((r_state == CLEAR) && (r_clr_addr == {ADDR_WIDTH{1'b1}})) begin
            w_state_nxt = RUN;
        end
    end

    // Zero-fill address counter, restarts at 0 after every reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clr_addr <= '0;
        end else if (w_clearing) begin
            r_clr_addr <= r_clr_addr + 1'b1;
        end
    end

    // First-stage response valid, aligned with the core read register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= w_resp;
        end
    end

    sp_ram_core #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .en      (w_core_en),
        .we      (w_core_we),
        .addr    (w_core_addr),
        .be      (w_core_be),
        .wdata   (w_core_wdata),
        .rd_en   (w_resp),
        .ret_new (w_ret_new),
        .q       (w_q)
    );

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic                  r_v2;
            logic [DATA_WIDTH-1:0] r_dout;

            // Extra output stage; data loads only alongside a valid response
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_v2   <= 1'b0;
                    r_dout <= '0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) begin
                        r_dout <= w_q;
                    end
                end
            end

            assign dout       = r_dout;
            assign dout_valid = r_v2;
        end else begin : g_lat1
            assign dout       = w_q;
            assign dout_valid = r_v1;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_be_clr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sp_ram_be_clr
//  Description : Directed bench for sp_ram_be_clr. Four instances share one
//                stimulus stream: defaults, RD_LATENCY=2, WR_RETURN=old,
//                WR_RETURN=new.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sp_ram_be_clr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  addr = '0;
    logic [3:0]  be   = '0;
    logic [31:0] din  = '0;

    logic        rdy0, rdy1, rdy2, rdy3;
    logic [31:0] do0, do1, do2, do3;
    logic        dv0, dv1, dv2, dv3;

    int passed = 0;
    int total  = 0;
    int rise;
    bit pulse;

    always #5 clk = ~clk;

    sp_ram_be_clr #(.RD_LATENCY(1), .WR_RETURN(0)) dut0 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .be(be), .din(din),
        .ready(rdy0), .dout(do0), .dout_valid(dv0));
    sp_ram_be_clr #(.RD_LATENCY(2), .WR_RETURN(0)) dut1 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .be(be), .din(din),
        .ready(rdy1), .dout(do1), .dout_valid(dv1));
    sp_ram_be_clr #(.RD_LATENCY(1), .WR_RETURN(2)) dut2 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .be(be), .din(din),
        .ready(rdy2), .dout(do2), .dout_valid(dv2));
    sp_ram_be_clr #(.RD_LATENCY(1), .WR_RETURN(1)) dut3 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .be(be), .din(din),
        .ready(rdy3), .dout(do3), .dout_valid(dv3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted access; returns #1 after the accepting edge
    task automatic access(input logic w, input logic [3:0] a, input logic [3:0] b,
                          input logic [31:0] d);
        req = 1'b1; we = w; addr = a; be = b; din = d;
        tick();
        req = 1'b0; we = 1'b0;
    endtask

    // Counts edges after reset release until ready; pokes a write at edge 5
    task automatic wait_clear(output int rise_at, output bit any_pulse);
        rise_at   = 0;
        any_pulse = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 5) begin
                req = 1'b1; we = 1'b1; addr = 4'd2; be = 4'hF; din = 32'hFFFF_FFFF;
            end
            tick();
            req = 1'b0; we = 1'b0;
            any_pulse = any_pulse | dv0 | dv1 | dv2 | dv3;
            if (rdy0 && rise_at == 0) begin
                rise_at = c;
                break;
            end
        end
    endtask

    initial begin
        repeat (3) tick();
        chk("reset_ready",  {31'd0, rdy0}, 32'd0);
        chk("reset_dout",   do1, 32'd0);
        chk("reset_dvalid", {31'd0, dv2}, 32'd0);

        rst = 1'b0;
        wait_clear(rise, pulse);
        chk("clear_ready_rise", rise, 32'd16);
        chk("clear_no_pulse",   {31'd0, pulse}, 32'd0);

        // Read after clear, latency 1 and 2
        access(1'b0, 4'd7, 4'h0, 32'd0);
        chk("rd7_lat1_valid", {31'd0, dv0}, 32'd1);
        chk("rd7_lat1_data",  do0, 32'd0);
        chk("rd7_lat2_early", {31'd0, dv1}, 32'd0);
        tick();
        chk("rd7_lat2_valid", {31'd0, dv1}, 32'd1);
        chk("rd7_lat1_drop",  {31'd0, dv0}, 32'd0);

        // Write issued during clear must have been ignored
        access(1'b0, 4'd2, 4'h0, 32'd0);
        chk("clr_req_ignored", do2, 32'd0);

        // Byte-enable merge
        access(1'b1, 4'd3, 4'hF, 32'hAABB_CCDD);
        chk("wr_none_no_pulse", {31'd0, dv0}, 32'd0);
        chk("wr_new_full",      do3, 32'hAABB_CCDD);
        chk("wr_old_full",      do2, 32'h0000_0000);
        access(1'b1, 4'd3, 4'h5, 32'h1122_3344);
        chk("wr_new_merge",     do3, 32'hAA22_CC44);
        chk("wr_old_merge",     do2, 32'hAABB_CCDD);
        access(1'b0, 4'd3, 4'h0, 32'd0);
        chk("rd3_merge",        do0, 32'hAA22_CC44);
        tick();
        chk("rd3_lat2",         do1, 32'hAA22_CC44);
        chk("dout_hold",        do0, 32'hAA22_CC44);

        // Back-to-back write then read of the same address
        access(1'b1, 4'd5, 4'hF, 32'hDEAD_BEEF);
        access(1'b0, 4'd5, 4'h0, 32'd0);
        chk("b2b_lat1",         do0, 32'hDEAD_BEEF);
        chk("b2b_lat2_nowr",    {31'd0, dv1}, 32'd0);
        tick();
        chk("b2b_lat2_valid",   {31'd0, dv1}, 32'd1);
        chk("b2b_lat2_data",    do1, 32'hDEAD_BEEF);
        tick();
        chk("b2b_lat2_single",  {31'd0, dv1}, 32'd0);

        // Old-word return
        access(1'b1, 4'd9, 4'hF, 32'h1234_5678);
        access(1'b1, 4'd9, 4'h3, 32'hFFFF_FFFF);
        chk("old_ret_valid",    {31'd0, dv2}, 32'd1);
        chk("old_ret_data",     do2, 32'h1234_5678);
        access(1'b0, 4'd9, 4'h0, 32'd0);
        chk("old_rd9",          do2, 32'h1234_FFFF);
        access(1'b1, 4'd9, 4'h0, 32'h0000_0000);
        chk("be0_ret_old",      do2, 32'h1234_FFFF);
        access(1'b0, 4'd9, 4'h0, 32'd0);
        chk("be0_no_change",    do0, 32'h1234_FFFF);

        // Reset while a latency-2 read is in flight
        access(1'b0, 4'd5, 4'h0, 32'd0);
        chk("pre_rst_valid",    {31'd0, dv0}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_dv_lat1",      {31'd0, dv0}, 32'd0);
        chk("rst_dv_lat2",      {31'd0, dv1}, 32'd0);
        chk("rst_dout_lat1",    do0, 32'd0);
        chk("rst_ready",        {31'd0, rdy1}, 32'd0);
        tick();
        tick();
        chk("rst_no_late",      {31'd0, dv1}, 32'd0);
        rst = 1'b0;
        wait_clear(rise, pulse);
        chk("reclear_rise",     rise, 32'd16);
        chk("reclear_no_pulse", {31'd0, pulse}, 32'd0);
        access(1'b0, 4'd5, 4'h0, 32'd0);
        chk("reclear_rd5_v",    {31'd0, dv0}, 32'd1);
        chk("reclear_rd5_d",    do0, 32'd0);
        access(1'b0, 4'd9, 4'h0, 32'd0);
        chk("reclear_rd9_d",    do2, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
